// File: rtl/calc_ctrl.sv
// Calculator sequencer: synchronises buttons, latches an ALU op on execute and writes the result back.
// Optional build macro CALC_CTRL_DEBOUNCE_EN adds a DEB_CYCLES stability filter on the execute button.
module calc_ctrl #(
  parameter int WIDTH      = 16,
  parameter int DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btnl,
  input  logic             btnc,
  input  logic             btnr,
  input  logic             btnd,
  input  logic             btnu,
  input  logic [WIDTH-1:0] sw,
  input  logic [WIDTH-1:0] alu_result,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] accum,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, EXEC, WB, WAIT_REL} state_t;

  state_t     state, next_state;
  logic [4:0] sync1, sync2;
  logic       l_sync, c_sync, r_sync, d_sync, u_sync;
  logic       d_level, d_prev, armed, go;
  logic [1:0] settle;
  logic [3:0] op_map;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btnl, btnc, btnr, btnd, btnu};
      sync2 <= sync1;
    end
  end

  assign {l_sync, c_sync, r_sync, d_sync, u_sync} = sync2;

`ifdef CALC_CTRL_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [CW-1:0] deb_cnt;
  logic          deb_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt   <= '0;
      deb_level <= 1'b0;
    end else if (!d_sync) begin
      deb_cnt   <= '0;
      deb_level <= 1'b0;
    end else if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
      deb_level <= 1'b1;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign d_level = deb_level;
`else
  assign d_level = d_sync;
`endif

  // The synchronisers read 0 right after reset, so a button held through reset would look like a
  // fresh press; go stays disarmed until the settled synchroniser has actually seen btnd low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle <= '0;
      d_prev <= 1'b0;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[0], 1'b1};
      d_prev <= d_level;
      if (settle[1] && !d_sync) armed <= 1'b1;
    end
  end

  assign go = armed & d_level & ~d_prev;

  always_comb begin
    // NOTE: default first so no path leaves op_map unassigned and infers a latch.
    op_map = 4'b0000;
    case ({l_sync, c_sync, r_sync})
      3'b000: op_map = 4'b0000;
      3'b001: op_map = 4'b0001;
      3'b010: op_map = 4'b0010;
      3'b011: op_map = 4'b0110;
      3'b100: op_map = 4'b0100;
      3'b101: op_map = 4'b1001;
      3'b110: op_map = 4'b1010;
      3'b111: op_map = 4'b0101;
      default: op_map = 4'b0000;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (!u_sync && go) next_state = EXEC;
      EXEC:     next_state = WB;
      WB:       next_state = WAIT_REL;
      WAIT_REL: if (!d_sync) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // The accumulator is written on the EXEC->WB edge so WB presents the new value with done high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      accum  <= '0;
      alu_op <= 4'b0000;
      alu_b  <= '0;
      done   <= 1'b0;
    end else begin
      state <= next_state;
      done  <= (state == EXEC);
      if (state == IDLE && u_sync) begin
        accum <= '0;
      end else if (state == IDLE && go) begin
        alu_op <= op_map;
        alu_b  <= sw;
      end
      if (state == EXEC) accum <= alu_result;
    end
  end

  assign alu_a = accum;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl with a small behavioural ALU; expected values are hand-computed.
// Define CALC_CTRL_DEBOUNCE_EN for both files to exercise the debounce build.
module tb_calc_ctrl;

  localparam int WIDTH = 16;
`ifdef CALC_CTRL_DEBOUNCE_EN
  localparam int DEB = 16;
`else
  localparam int DEB = 0;
`endif
  localparam int LAT = 2 + DEB;  // edges after edge k until EXEC is entered

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             btnl = 0, btnc = 0, btnr = 0, btnd = 0, btnu = 0;
  logic [WIDTH-1:0] sw = '0;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, accum;
  logic             busy, done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  calc_ctrl #(.WIDTH(WIDTH), .DEB_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .btnl(btnl), .btnc(btnc), .btnr(btnr), .btnd(btnd), .btnu(btnu),
    .sw(sw), .alu_result(alu_result),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .accum(accum),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      4'b0001: alu_result = alu_a + alu_b;
      4'b0010: alu_result = alu_a - alu_b;
      4'b0110: alu_result = alu_a & alu_b;
      4'b0100: alu_result = alu_a | alu_b;
      4'b1001: alu_result = alu_a ^ alu_b;
      4'b1010: alu_result = ~alu_a;
      4'b0101: alu_result = alu_b;
      default: alu_result = alu_a;
    endcase
  end

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Press execute with {l,c,r}=lcr and sw=b; buttons and sw are scrambled during EXEC to prove they
  // were latched. Optionally holds btnd longer and pulses btnu while the FSM waits for release.
  task automatic do_op(input string tag, input logic [2:0] lcr, input logic [WIDTH-1:0] b,
                       input logic [3:0] exp_op, input logic [WIDTH-1:0] exp_acc,
                       input int hold, input bit pulse_u);
    @(negedge clk);
    {btnl, btnc, btnr} = lcr;
    sw   = b;
    btnd = 1'b1;
    repeat (LAT + 1) @(posedge clk);
    @(negedge clk);
    check({tag, "_exec_busy"}, 32'({busy, done}), 32'b10);
    sw = ~b;
    {btnl, btnc, btnr} = ~lcr;
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_accum"}, 32'(accum), 32'(exp_acc));
    check({tag, "_op"}, 32'(alu_op), 32'(exp_op));
    check({tag, "_b"}, 32'(alu_b), 32'(b));
    @(negedge clk);
    check({tag, "_done_low"}, 32'(done), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      btnu = pulse_u && (i < 5);
    end
    btnu = 1'b0;
    if (hold > 0) check({tag, "_hold_acc"}, 32'(accum), 32'(exp_acc));
    btnd = 1'b0;
    wait_idle(tag);
  endtask

  initial begin
    int d0;
    bit saw_busy;
    repeat (3) @(negedge clk);
    check("rst_accum", 32'(accum), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_op", 32'(alu_op), 32'd0);
    check("rst_busy_done", 32'({busy, done}), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Preload 5 via pass-B, then add 3.
    do_op("pre5", 3'b111, 16'h0005, 4'b0101, 16'h0005, 0, 0);
    do_op("add3", 3'b001, 16'h0003, 4'b0001, 16'h0008, 0, 0);

    // All eight op selections.
    do_op("op000", 3'b000, 16'h1111, 4'b0000, 16'h0008, 0, 0);
    do_op("op001", 3'b001, 16'h0002, 4'b0001, 16'h000A, 0, 0);
    do_op("op010", 3'b010, 16'h0003, 4'b0010, 16'h0007, 0, 0);
    do_op("op011", 3'b011, 16'h0005, 4'b0110, 16'h0005, 0, 0);
    do_op("op100", 3'b100, 16'h00F0, 4'b0100, 16'h00F5, 0, 0);
    do_op("op101", 3'b101, 16'h0FF0, 4'b1001, 16'h0F05, 0, 0);
    do_op("op110", 3'b110, 16'h0000, 4'b1010, 16'hF0FA, 0, 0);
    do_op("op111", 3'b111, 16'hFFFF, 4'b0101, 16'hFFFF, 0, 0);
    do_op("wrap",  3'b001, 16'h0001, 4'b0001, 16'h0000, 0, 0);

    // Long hold: one pulse only; btnu outside IDLE ignored; re-press gives a second pulse.
    d0 = done_cnt;
    do_op("hold", 3'b001, 16'h0042, 4'b0001, 16'h0042, 45, 1);
    check("hold_one_pulse", 32'(done_cnt - d0), 32'd1);
    do_op("repress", 3'b001, 16'h0001, 4'b0001, 16'h0043, 0, 0);
    check("repress_two_pulses", 32'(done_cnt - d0), 32'd2);

    // Clear and execute coincident in IDLE: clear wins.
    do_op("pre1234", 3'b111, 16'h1234, 4'b0101, 16'h1234, 0, 0);
    d0 = done_cnt;
    saw_busy = 0;
    @(negedge clk);
    {btnl, btnc, btnr} = 3'b001;
    btnu = 1'b1;
    btnd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1;
    end
    btnu = 1'b0;
    btnd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1;
    end
    check("clr_accum", 32'(accum), 32'd0);
    check("clr_no_busy", 32'(saw_busy), 32'd0);
    check("clr_no_done", 32'(done_cnt - d0), 32'd0);

    // Reset during EXEC aborts the write-back; btnd held through reset must not retrigger.
    d0 = done_cnt;
    @(negedge clk);
    {btnl, btnc, btnr} = 3'b111;
    sw   = 16'h5555;
    btnd = 1'b1;
    repeat (LAT + 1) @(posedge clk);
    @(negedge clk);
    check("rst_exec_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_async_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (12 + DEB) @(negedge clk);
    check("rst_abort_accum", 32'(accum), 32'd0);
    check("rst_abort_done", 32'(done_cnt - d0), 32'd0);
    check("rst_abort_idle", 32'(busy), 32'd0);
    btnd = 1'b0;
    repeat (4) @(negedge clk);
    do_op("fresh", 3'b001, 16'h0007, 4'b0001, 16'h0007, 0, 0);

`ifdef CALC_CTRL_DEBOUNCE_EN
    // A 10-cycle glitch never satisfies the stability count.
    d0 = done_cnt;
    @(negedge clk);
    btnd = 1'b1;
    repeat (10) @(negedge clk);
    btnd = 1'b0;
    repeat (30) @(negedge clk);
    check("glitch_no_done", 32'(done_cnt - d0), 32'd0);
    check("glitch_idle", 32'(busy), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
